// File: rtl/tracker_axis_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tracker_axis_ctrl
// Description : Single-axis solar tracker controller. It turns paired sensor
//               readings into servo step and sweep requests.
// Revision    : 1.0
// ============================================================================
module tracker_axis_ctrl #(
    parameter int unsigned W             = 12,
    parameter int unsigned DEADBAND      = 32,
    parameter int unsigned DARK_TH       = 400,
    parameter int unsigned HYST          = 64,
    parameter int unsigned STEP_CYCLES   = 100000,
    parameter int unsigned SETTLE_CYCLES = 2000000,
    parameter int unsigned POS_MIN       = 5000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ADC_VALID,
    input  logic [W-1:0] ADC_A,
    input  logic [W-1:0] ADC_B,
    input  logic         PWM_LIMIT,
    input  logic [31:0]  SERVO_POS,
    output logic         BTN_0,
    output logic         BTN_1,
    output logic         ES,
    output logic         LOCKED,
    output logic [2:0]   STATE
);

    typedef enum logic [2:0] {
        S_SAMPLE   = 3'd0,
        S_MOVE_CCW = 3'd1,
        S_MOVE_CW  = 3'd2,
        S_SETTLE   = 3'd3,
        S_SWEEP_UP = 3'd4,
        S_SWEEP_DN = 3'd5
    } state_t;

    localparam int unsigned c_EXIT_TH = DARK_TH + HYST;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_cnt;
    logic signed [W:0] w_diff;
    logic [W:0]        w_sum;
    logic [W:0]        w_abs;
    logic [31:0]       w_sum32;
    logic [31:0]       w_abs32;
    logic              w_dark;
    logic              w_aligned;
    logic              w_light;
    logic              w_at_floor;
    logic              w_step_done;
    logic              w_settle_done;
    logic              w_lock_upd;
    logic              w_lock_val;

    // Both operands zero-extended so the difference and sum never wrap.
    assign w_diff  = $signed({1'b0, ADC_A}) - $signed({1'b0, ADC_B});
    assign w_sum   = {1'b0, ADC_A} + {1'b0, ADC_B};
    assign w_abs   = w_diff[W] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_sum32 = 32'(w_sum);
    assign w_abs32 = 32'(w_abs);

    assign w_dark        = w_sum32 < DARK_TH;
    assign w_aligned     = w_abs32 <= DEADBAND;
    assign w_light       = ADC_VALID && (w_sum32 >= c_EXIT_TH);
    assign w_at_floor    = SERVO_POS <= POS_MIN;
    assign w_step_done   = r_cnt == (STEP_CYCLES - 32'd1);
    assign w_settle_done = r_cnt == (SETTLE_CYCLES - 32'd1);

    always_comb begin
        w_next     = r_state;
        w_lock_upd = 1'b0;
        w_lock_val = 1'b0;
        case (r_state)
            S_SAMPLE: begin
                if (ADC_VALID) begin
                    w_lock_upd = 1'b1;
                    if (w_dark)
                        w_next = S_SWEEP_UP;
                    else if (w_aligned)
                        w_lock_val = 1'b1;
                    else if (!w_diff[W])
                        w_next = PWM_LIMIT ? S_SETTLE : S_MOVE_CCW;
                    else
                        w_next = w_at_floor ? S_SETTLE : S_MOVE_CW;
                end
            end
            S_MOVE_CCW: if (PWM_LIMIT || w_step_done) w_next = S_SETTLE;
            S_MOVE_CW:  if (w_at_floor || w_step_done) w_next = S_SETTLE;
            S_SETTLE:   if (w_settle_done) w_next = S_SAMPLE;
            // Light exit outranks the mechanical limit seen in the same cycle.
            S_SWEEP_UP: begin
                if (w_light)
                    w_next = S_SETTLE;
                else if (PWM_LIMIT)
                    w_next = S_SWEEP_DN;
            end
            S_SWEEP_DN: if (w_light || w_at_floor) w_next = S_SETTLE;
            default:    w_next = S_SAMPLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_SAMPLE;
            r_cnt   <= '0;
            BTN_0   <= 1'b0;
            BTN_1   <= 1'b0;
            ES      <= 1'b0;
            LOCKED  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 32'd0 : r_cnt + 32'd1;
            BTN_0   <= (w_next == S_MOVE_CCW) || (w_next == S_SWEEP_UP);
            BTN_1   <= (w_next == S_MOVE_CW)  || (w_next == S_SWEEP_DN);
            ES      <= (w_next == S_SWEEP_UP) || (w_next == S_SWEEP_DN);
            if (w_lock_upd)
                LOCKED <= w_lock_val;
        end
    end

    assign STATE = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tracker_axis_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tracker_axis_ctrl
// Description : Randomized self-checking bench for tracker_axis_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_tracker_axis_ctrl;

    localparam int c_DB      = 32;
    localparam int c_DARK    = 400;
    localparam int c_HYST    = 64;
    localparam int c_STEP    = 10;
    localparam int c_SETTLE  = 20;
    localparam int c_POS_MIN = 5000;
    localparam int c_EXIT    = c_DARK + c_HYST;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ADC_VALID = 1'b0;
    logic [11:0] ADC_A = '0;
    logic [11:0] ADC_B = '0;
    logic        PWM_LIMIT = 1'b0;
    logic [31:0] SERVO_POS = 32'd20000;
    logic        BTN_0;
    logic        BTN_1;
    logic        ES;
    logic        LOCKED;
    logic [2:0]  STATE;

    int n_vec = 0;
    int n_err = 0;
    int exp_locked = 0;

    always #5 CLK = ~CLK;

    tracker_axis_ctrl #(
        .W(12), .DEADBAND(c_DB), .DARK_TH(c_DARK), .HYST(c_HYST),
        .STEP_CYCLES(c_STEP), .SETTLE_CYCLES(c_SETTLE), .POS_MIN(c_POS_MIN)
    ) dut (
        .CLK(CLK), .RST(RST), .ADC_VALID(ADC_VALID), .ADC_A(ADC_A), .ADC_B(ADC_B),
        .PWM_LIMIT(PWM_LIMIT), .SERVO_POS(SERVO_POS), .BTN_0(BTN_0), .BTN_1(BTN_1),
        .ES(ES), .LOCKED(LOCKED), .STATE(STATE)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference decision for a sample taken in SAMPLE.
    function automatic int model_next(input int a, input int b, input bit lim, input longint pos);
        int sum;
        int diff;
        int mag;
        sum  = a + b;
        diff = a - b;
        mag  = (diff < 0) ? -diff : diff;
        if (sum < c_DARK) return 4;
        if (mag <= c_DB) return 0;
        if (diff > 0) return lim ? 3 : 1;
        return (pos > c_POS_MIN) ? 2 : 3;
    endfunction

    task automatic strobe(input int a, input int b, input bit lim, input logic [31:0] pos);
        @(negedge CLK);
        ADC_VALID = 1'b1;
        ADC_A     = 12'(a);
        ADC_B     = 12'(b);
        PWM_LIMIT = lim;
        SERVO_POS = pos;
        @(negedge CLK);
        ADC_VALID = 1'b0;
    endtask

    task automatic run_settle(input string tag);
        int n = 0;
        bit bad = 1'b0;
        while (STATE == 3'd3 && n < 1000) begin
            n++;
            if (BTN_0 || BTN_1 || ES) bad = 1'b1;
            ADC_VALID = ($urandom_range(0, 3) == 0);
            ADC_A     = 12'($urandom);
            ADC_B     = 12'($urandom);
            @(negedge CLK);
        end
        ADC_VALID = 1'b0;
        chk({tag, "_settle_len"}, n, c_SETTLE);
        chk({tag, "_settle_outs"}, bad, 0);
        chk({tag, "_back_sample"}, STATE, 0);
        chk({tag, "_locked_hold"}, LOCKED, exp_locked);
    endtask

    task automatic run_move(input int dir);
        int n = 0;
        int ab;
        bit both = 1'b0;
        bit wrong = 1'b0;
        ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, c_STEP - 1)) : 0;
        while (STATE == 3'(dir) && n < 1000) begin
            if (BTN_0 && BTN_1) both = 1'b1;
            if (ES || (dir == 1 ? BTN_1 : BTN_0)) wrong = 1'b1;
            if (dir == 1 ? BTN_0 : BTN_1) n++;
            if (ab != 0 && n == ab) begin
                if (dir == 1) PWM_LIMIT = 1'b1;
                else SERVO_POS = $urandom_range(0, c_POS_MIN);
            end
            ADC_VALID = ($urandom_range(0, 3) == 0);
            ADC_A     = 12'($urandom);
            ADC_B     = 12'($urandom);
            @(negedge CLK);
        end
        ADC_VALID = 1'b0;
        chk(ab != 0 ? "move_abort_len" : "move_len", n, ab != 0 ? ab : c_STEP);
        chk("move_excl", {both, wrong}, 0);
        chk("move_to_settle", STATE, 3);
        run_settle("move");
    endtask

    function automatic int light_sum();
        return ($urandom_range(0, 3) == 0) ? c_EXIT : int'($urandom_range(c_EXIT, 8190));
    endfunction

    task automatic run_sweep();
        int s;
        int v;
        repeat ($urandom_range(1, 4)) @(negedge CLK);
        chk("sweep_up_idle", {STATE, BTN_0, BTN_1, ES}, {3'd4, 1'b1, 1'b0, 1'b1});
        s = ($urandom_range(0, 3) == 0) ? c_EXIT - 1 : int'($urandom_range(c_DARK, c_EXIT - 1));
        strobe(s / 2, s - s / 2, 1'b0, SERVO_POS);
        chk("sweep_noexit", STATE, 4);
        v = $urandom_range(0, 2);
        if (v == 0) begin
            s = light_sum();
            strobe(s / 2, s - s / 2, 1'b0, SERVO_POS);
            chk("sweep_up_exit", STATE, 3);
        end else if (v == 2) begin
            s = light_sum();
            strobe(s / 2, s - s / 2, 1'b1, SERVO_POS);
            chk("sweep_prio", STATE, 3);
        end else begin
            @(negedge CLK);
            PWM_LIMIT = 1'b1;
            @(negedge CLK);
            chk("sweep_dn", {STATE, BTN_0, BTN_1, ES}, {3'd5, 1'b0, 1'b1, 1'b1});
            if ($urandom_range(0, 1) == 1) begin
                s = light_sum();
                strobe(s / 2, s - s / 2, 1'b1, SERVO_POS);
                chk("sweep_dn_exit", STATE, 3);
            end else begin
                SERVO_POS = $urandom_range(0, c_POS_MIN);
                @(negedge CLK);
                chk("sweep_floor", STATE, 3);
            end
        end
        run_settle("sweep");
        PWM_LIMIT = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1 chk({tag, "_async"}, {STATE, BTN_0, BTN_1, ES, LOCKED}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk({tag, "_release"}, {STATE, BTN_0, BTN_1, ES, LOCKED}, 0);
        exp_locked = 0;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("reset", {STATE, BTN_0, BTN_1, ES, LOCKED}, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("reset_idle", STATE, 0);

        for (int t = 0; t < 60; t++) begin
            int mode;
            int a;
            int b;
            int s;
            int e;
            bit lim;
            logic [31:0] pos;
            mode = $urandom_range(0, 4);
            lim  = 1'b0;
            pos  = $urandom_range(c_POS_MIN + 1, 60000);
            case (mode)
                0: begin
                    s = ($urandom_range(0, 3) == 0) ? c_DARK : int'($urandom_range(0, c_DARK - 1));
                    a = $urandom_range(0, s);
                    b = s - a;
                end
                1: begin
                    a = $urandom_range(300, 3800);
                    b = a + int'($urandom_range(0, 64)) - 32;
                end
                2: begin
                    b   = $urandom_range(300, 3000);
                    a   = b + (($urandom_range(0, 1) == 1) ? 33 : int'($urandom_range(33, 1000)));
                    lim = ($urandom_range(0, 3) == 0);
                end
                3: begin
                    a = $urandom_range(300, 3000);
                    b = a + (($urandom_range(0, 1) == 1) ? 33 : int'($urandom_range(33, 1000)));
                    if ($urandom_range(0, 2) == 0)
                        pos = c_POS_MIN + $urandom_range(0, 1);
                end
                default: begin
                    a = $urandom_range(0, 4095);
                    b = $urandom_range(0, 4095);
                end
            endcase
            strobe(a, b, lim, pos);
            e = model_next(a, b, lim, pos);
            exp_locked = (e == 0) ? 1 : 0;
            chk("state", STATE, e);
            chk("locked", LOCKED, exp_locked);
            chk("btn0", BTN_0, (e == 1 || e == 4) ? 1 : 0);
            chk("btn1", BTN_1, (e == 2) ? 1 : 0);
            chk("es", ES, (e == 4) ? 1 : 0);
            case (e)
                0: begin
                    repeat (3) @(negedge CLK);
                    chk("aligned_hold", {STATE, BTN_0, BTN_1, ES, LOCKED}, 1);
                end
                1, 2: run_move(e);
                3: run_settle("nomove");
                default: run_sweep();
            endcase
            PWM_LIMIT = 1'b0;
        end

        strobe(100, 100, 1'b0, 32'd20000);
        chk("dark_entry", STATE, 4);
        reset_pulse("rst_sweep");
        strobe(2000, 1800, 1'b0, 32'd20000);
        chk("ccw_entry", STATE, 1);
        repeat (3) @(negedge CLK);
        reset_pulse("rst_move");
        strobe(2000, 1800, 1'b0, 32'd20000);
        chk("post_rst_ccw", STATE, 1);
        run_move(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
